// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Two-port arbiter/sequencer for a single-port RAM; one access
//               per three cycles, RAM samples on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t r_state;
  logic   r_gnt;
  logic   r_rr_last;
  logic   w_any;
  logic   w_pick1;

  assign w_any = req0 | req1;

  // Port 1 wins only when alone, or on a tie when port 0 was served last.
  generate
    if (FIXED_PRIO != 0) begin : g_fixed
      assign w_pick1 = req1 & ~req0;
    end else begin : g_rr
      assign w_pick1 = req1 & (~req0 | ~r_rr_last);
    end
  endgenerate

  assign busy = (r_state != ST_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_gnt       <= 1'b0;
      r_rr_last   <= 1'b1;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt       <= w_pick1;
            r_rr_last   <= w_pick1;
            ram_cs      <= 1'b1;
            ram_we      <= w_pick1 ? we1 : we0;
            ram_address <= w_pick1 ? addr1 : addr0;
            ram_data_in <= w_pick1 ? wdata1 : wdata0;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // ram_we still holds the granted direction until this edge.
          if (!ram_we) begin
            if (r_gnt) rdata1 <= ram_data_out;
            else       rdata0 <= ram_data_out;
          end
          ram_cs  <= 1'b0;
          ram_we  <= 1'b0;
          ack0    <= ~r_gnt;
          ack1    <= r_gnt;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Randomised and directed bench for ram_arbiter, round-robin and
//               fixed-priority instances against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;

  logic          ack0_s[2], ack1_s[2], cs_s[2], we_s[2], busy_s[2];
  logic [DW-1:0] rd0_s[2], rd1_s[2], din_s[2], dout_s[2];
  logic [AW-1:0] addr_s[2];
  logic [DW-1:0] ram[2][0:(1<<AW)-1];

  int  total = 0;
  int  bad = 0;
  bit  chk_on = 1'b0;

  always #5 clock = ~clock;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0)) dut_rr (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_s[0]), .rdata0(rd0_s[0]),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_s[0]), .rdata1(rd1_s[0]),
    .ram_cs(cs_s[0]), .ram_we(we_s[0]), .ram_address(addr_s[0]), .ram_data_in(din_s[0]),
    .ram_data_out(dout_s[0]), .busy(busy_s[0]));

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1)) dut_fp (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_s[1]), .rdata0(rd0_s[1]),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_s[1]), .rdata1(rd1_s[1]),
    .ram_cs(cs_s[1]), .ram_we(we_s[1]), .ram_address(addr_s[1]), .ram_data_in(din_s[1]),
    .ram_data_out(dout_s[1]), .busy(busy_s[1]));

  // RAM slaves: act on the falling edge only while selected; contents survive reset.
  initial begin
    for (int k = 0; k < 2; k++) begin
      dout_s[k] = '0;
      for (int a = 0; a < (1<<AW); a++) ram[k][a] = '0;
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin : b_ram
      if (cs_s[k]) begin
        if (we_s[k]) ram[k][addr_s[k]] <= din_s[k];
        else         dout_s[k] <= ram[k][addr_s[k]];
      end
    end
  end

  task automatic chk(input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL inst%0d %s: got %0h expected %0h at %0t", k, nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is granted at posedge g, accesses the RAM in
  // cycle g, acks in cycle g+1, and the next grant can happen at posedge g+3.
  int            n = 0;
  int            g[2] = '{0, 0};
  bit            hv[2] = '{1'b0, 1'b0};
  bit            last[2] = '{1'b1, 1'b1};
  bit            t_w[2], t_we[2], t_done[2];
  logic [AW-1:0] t_addr[2], e_addr[2] = '{'0, '0};
  logic [DW-1:0] t_data[2], t_rval[2];
  logic [DW-1:0] e_din[2] = '{'0, '0}, e_rd0[2] = '{'0, '0}, e_rd1[2] = '{'0, '0};
  logic [DW-1:0] ref_mem[2][0:(1<<AW)-1];

  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < (1<<AW); a++) ref_mem[k][a] = '0;
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin : b_mrst
        hv[k] = 1'b0; last[k] = 1'b1;
        e_rd0[k] = '0; e_rd1[k] = '0; e_addr[k] = '0; e_din[k] = '0;
      end
    end else begin
      n = n + 1;
      for (int k = 0; k < 2; k++) begin : b_mstep
        bit w;
        if (hv[k] && (n - g[k] == 1) && t_done[k] && !t_we[k]) begin
          if (t_w[k]) e_rd1[k] = t_rval[k];
          else        e_rd0[k] = t_rval[k];
        end
        if ((!hv[k] || (n - g[k] >= 3)) && (req0 || req1)) begin
          if (req0 && req1) w = (k == 1) ? 1'b0 : ~last[k];
          else              w = req1;
          last[k]   = w;
          hv[k]     = 1'b1;
          g[k]      = n;
          t_w[k]    = w;
          t_we[k]   = w ? we1 : we0;
          t_addr[k] = w ? addr1 : addr0;
          t_data[k] = w ? wdata1 : wdata0;
          t_done[k] = 1'b0;
          e_addr[k] = t_addr[k];
          e_din[k]  = t_data[k];
        end
      end
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin : b_cmp
      int d;
      bit acc;
      d   = n - g[k];
      acc = hv[k] && (d == 0);
      if (acc && !reset && !t_done[k]) begin
        if (t_we[k]) ref_mem[k][t_addr[k]] = t_data[k];
        else         t_rval[k] = ref_mem[k][t_addr[k]];
        t_done[k] = 1'b1;
      end
      if (chk_on) begin
        chk(k, "ram_cs", cs_s[k], acc);
        chk(k, "ram_we", we_s[k], acc && t_we[k]);
        chk(k, "busy", busy_s[k], hv[k] && (d <= 1));
        chk(k, "ack0", ack0_s[k], hv[k] && (d == 1) && !t_w[k]);
        chk(k, "ack1", ack1_s[k], hv[k] && (d == 1) && t_w[k]);
        chk(k, "rdata0", rd0_s[k], e_rd0[k]);
        chk(k, "rdata1", rd1_s[k], e_rd1[k]);
        chk(k, "ram_address", addr_s[k], e_addr[k]);
        chk(k, "ram_data_in", din_s[k], e_din[k]);
      end
    end
  end

  // Single request on one port; observes the round-robin instance.
  task automatic xfer(input bit p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output logic [DW-1:0] rd, output int lat, output int wec,
                      output int oth, output logic [AW-1:0] seen_a);
    lat = 0; wec = 0; oth = 0; rd = '0; seen_a = '0;
    @(posedge clock); #1;
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clock);
      if (we_s[0]) wec++;
      if (cs_s[0]) seen_a = addr_s[0];
      if (p ? ack1_s[0] : ack0_s[0]) begin lat = c; rd = p ? rd1_s[0] : rd0_s[0]; end
      if (p ? ack0_s[0] : ack1_s[0]) oth++;
    end
    @(posedge clock); #1;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin : main
    logic [DW-1:0] rd;
    logic [AW-1:0] sa;
    logic [5:0]    seq_rr;
    int lat, wec, oth, c0, c1, f0, f1, nrr, fp0, fp1, acks, a1, a2;
    logic [DW-1:0] r0v, r1v;

    #1 reset = 1'b1;
    #1 chk_on = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk(9, "reset_ack0", ack0_s[0], 1'b0);
    chk(9, "reset_cs", cs_s[0], 1'b0);

    // Write then read back on port 0.
    xfer(1'b0, 1'b1, 11'd5, 32'hDEADBEEF, rd, lat, wec, oth, sa);
    chk(9, "t1_wr_lat", lat, 3);
    chk(9, "t1_wr_we_cycles", wec, 1);
    chk(9, "t1_wr_ack1", oth, 0);
    xfer(1'b0, 1'b0, 11'd5, 32'h0, rd, lat, wec, oth, sa);
    chk(9, "t1_rd_lat", lat, 3);
    chk(9, "t1_rd_data", rd, 32'hDEADBEEF);
    chk(9, "t1_rd_we_cycles", wec, 0);
    chk(9, "t1_rd_ack1", oth, 0);

    // Top address on port 1.
    xfer(1'b1, 1'b1, 11'h7FF, 32'h1, rd, lat, wec, oth, sa);
    chk(9, "t4_addr", sa, 11'h7FF);
    chk(9, "t4_wr_ack0", oth, 0);
    xfer(1'b1, 1'b0, 11'h7FF, 32'h0, rd, lat, wec, oth, sa);
    chk(9, "t4_rd_data", rd, 32'h1);
    chk(9, "t4_rd_lat", lat, 3);

    // Simultaneous reads: port 0 first, port 1 three cycles later.
    @(posedge clock); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'd5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 11'h7FF;
    c0 = 0; c1 = 0; f0 = 0; f1 = 0; r0v = '0; r1v = '0;
    for (int c = 1; c <= 10 && c1 == 0; c++) begin
      @(negedge clock);
      if (ack0_s[0] && c0 == 0) begin c0 = c; r0v = rd0_s[0]; end
      if (ack1_s[0] && c1 == 0) begin c1 = c; r1v = rd1_s[0]; end
      if (ack0_s[1] && f0 == 0) f0 = c;
      if (ack1_s[1] && f1 == 0) f1 = c;
      @(posedge clock); #1;
      if (c0 != 0) req0 = 1'b0;
      if (c1 != 0) req1 = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk(9, "t2_ack0_cycle", c0, 3);
    chk(9, "t2_ack1_cycle", c1, 6);
    chk(9, "t2_rdata0", r0v, 32'hDEADBEEF);
    chk(9, "t2_rdata1", r1v, 32'h1);
    chk(9, "t2_fp_ack0_cycle", f0, 3);
    chk(9, "t2_fp_ack1_cycle", f1, 6);

    // Both ports requesting continuously for six accesses.
    @(posedge clock); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'd5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 11'h7FF;
    seq_rr = '0; nrr = 0; fp0 = 0; fp1 = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clock);
      if (ack0_s[0]) begin seq_rr = {seq_rr[4:0], 1'b0}; nrr++; end
      if (ack1_s[0]) begin seq_rr = {seq_rr[4:0], 1'b1}; nrr++; end
      if (ack0_s[1]) fp0++;
      if (ack1_s[1]) fp1++;
    end
    @(posedge clock); #1;
    req0 = 1'b0; req1 = 1'b0;
    chk(9, "t3_rr_grants", nrr, 6);
    chk(9, "t3_rr_order", seq_rr, 6'b010101);
    chk(9, "t3_fp_port0", fp0, 6);
    chk(9, "t3_fp_port1", fp1, 0);
    repeat (3) @(posedge clock);

    // Reset during the BUSY cycle of a write, before the RAM edge.
    xfer(1'b0, 1'b1, 11'd3, 32'hA, rd, lat, wec, oth, sa);
    @(posedge clock); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'd3; wdata0 = 32'hB;
    @(posedge clock); #1;
    chk(9, "t5_cs_granted", cs_s[0], 1'b1);
    reset = 1'b1; req0 = 1'b0;
    #1;
    chk(9, "t5_cs_dropped", cs_s[0], 1'b0);
    chk(9, "t5_busy_dropped", busy_s[0], 1'b0);
    acks = 0;
    repeat (3) begin
      @(negedge clock);
      if (ack0_s[0] || ack1_s[0]) acks++;
    end
    @(posedge clock); #1 reset = 1'b0;
    chk(9, "t5_no_ack", acks, 0);
    xfer(1'b0, 1'b0, 11'd3, 32'h0, rd, lat, wec, oth, sa);
    chk(9, "t5_old_data", rd, 32'hA);

    // Stale request held through RESP starts a second access.
    @(posedge clock); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'd5;
    acks = 0; a1 = 0; a2 = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      if (ack0_s[0]) begin
        acks++;
        if (a1 == 0) a1 = c; else if (a2 == 0) a2 = c;
      end
      if (c == 6) begin @(posedge clock); #1 req0 = 1'b0; end
    end
    chk(9, "t6_ack_count", acks, 2);
    chk(9, "t6_first_ack", a1, 3);
    chk(9, "t6_second_ack", a2, 6);

    // Random traffic with occasional mid-cycle resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      req0   = ($urandom % 3) != 0;
      we0    = $urandom % 2;
      addr0  = ($urandom % 8 == 0) ? 11'h7FF : AW'($urandom_range(0, 7));
      wdata0 = $urandom;
      req1   = ($urandom % 3) != 0;
      we1    = $urandom % 2;
      addr1  = ($urandom % 8 == 0) ? 11'h7FF : AW'($urandom_range(0, 7));
      wdata1 = $urandom;
      reset  = ($urandom % 150) == 0;
    end
    @(posedge clock); #1;
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
